// File: rtl/vga_fb_pkg.sv
// Shared VGA 640x480@60 timing and frame-buffer geometry for the display-side reader.
// Also holds the small address and nibble helpers used by the reader.
package vga_fb_pkg;

    localparam logic [9:0] H_VISIBLE = 10'd640;
    localparam logic [9:0] H_FP      = 10'd16;
    localparam logic [9:0] H_SYNC    = 10'd96;
    localparam logic [9:0] H_BP      = 10'd48;
    localparam logic [9:0] H_TOTAL   = 10'd800;

    localparam logic [9:0] V_VISIBLE = 10'd480;
    localparam logic [9:0] V_FP      = 10'd10;
    localparam logic [9:0] V_SYNC    = 10'd2;
    localparam logic [9:0] V_BP      = 10'd33;
    localparam logic [9:0] V_TOTAL   = 10'd525;

    localparam logic [6:0]  WORDS_PER_ROW = 7'd80;
    localparam logic [14:0] FB_DEPTH      = 15'd19200;
    localparam logic [2:0]  PIX_PER_WORD  = 3'd4;

    localparam logic [9:0] H_LAST       = H_TOTAL - 10'd1;
    localparam logic [9:0] V_LAST       = V_TOTAL - 10'd1;
    localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FP;
    localparam logic [9:0] H_SYNC_END   = H_VISIBLE + H_FP + H_SYNC - 10'd1;
    localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FP;
    localparam logic [9:0] V_SYNC_END   = V_VISIBLE + V_FP + V_SYNC - 10'd1;

    // Fetches for words 1..79 sit below this column; word 0 of the next line is fetched at H_ROW_FETCH.
    localparam logic [9:0] H_FETCH_LIMIT = 10'd632;
    localparam logic [9:0] H_ROW_FETCH   = 10'd796;

    typedef enum logic [2:0] {
        PH_FETCH   = 3'd4,
        PH_CAPTURE = 3'd6,
        PH_ADVANCE = 3'd7
    } word_phase_e;

    function automatic logic [14:0] row_base(input logic [9:0] line);
        logic [14:0] src_row;
        src_row = {5'd0, line} >> 3'd1;
        return (src_row << 3'd6) + (src_row << 3'd4);
    endfunction

    function automatic logic [3:0] nibble_sel(input logic [15:0] word, input logic [1:0] idx);
        logic [3:0] nib;
        case (idx)
            2'd0:    nib = word[3:0];
            2'd1:    nib = word[7:4];
            2'd2:    nib = word[11:8];
            2'd3:    nib = word[15:12];
            default: nib = 4'd0;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel/line counters for 640x480@60 plus the visible flag and raw (unregistered) active-low syncs.
module vga_timing_gen
    import vga_fb_pkg::*;
(
    input  logic       p_clock,
    input  logic       reset,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic       visible,
    output logic       hsync_raw,
    output logic       vsync_raw
);

    logic [9:0] hc_r;
    logic [9:0] vc_r;

    // Horizontal counter wraps at 799 and steps the vertical counter, which wraps at 524.
    always_ff @(posedge p_clock or posedge reset) begin
        if (reset) begin
            hc_r <= 10'd0;
            vc_r <= 10'd0;
        end else if (hc_r >= H_LAST) begin
            hc_r <= 10'd0;
            if (vc_r >= V_LAST) begin
                vc_r <= 10'd0;
            end else begin
                vc_r <= vc_r + 10'd1;
            end
        end else begin
            hc_r <= hc_r + 10'd1;
        end
    end

    // Decode of the current counter position.
    always_comb begin
        hc        = hc_r;
        vc        = vc_r;
        visible   = (hc_r < H_VISIBLE) && (vc_r < V_VISIBLE);
        hsync_raw = ~((hc_r >= H_SYNC_START) && (hc_r <= H_SYNC_END));
        vsync_raw = ~((vc_r >= V_SYNC_START) && (vc_r <= V_SYNC_END));
    end

endmodule

// File: rtl/frame_buffer_vga_reader.sv
// Display-side reader: scans the 320x240 4-bit gray frame buffer, upscales 2x, drives 640x480@60 VGA.
// Optional GRAY_BARS_EN adds a test_mode input that replaces memory gray with ten 64-column bars.
module frame_buffer_vga_reader
    import vga_fb_pkg::*;
(
    input  logic        p_clock,
    input  logic        reset,
`ifdef GRAY_BARS_EN
    input  logic        test_mode,
`endif
    input  logic [15:0] mem_data,
    output logic [14:0] addr,
    output logic        ena,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue
);

    logic [9:0]  hc_s;
    logic [9:0]  vc_s;
    logic        visible_s;
    logic        hsync_raw_s;
    logic        vsync_raw_s;

    logic        fetch_s;
    logic [9:0]  next_line_s;
    logic [9:0]  target_line_s;
    logic [6:0]  word_idx_s;
    logic [14:0] fetch_addr_s;
    logic [3:0]  gray_s;

    logic [14:0] addr_r;
    logic        ena_r;
    logic [15:0] next_word_r;
    logic [15:0] cur_word_r;
    logic        hsync_r;
    logic        vsync_r;
    logic [3:0]  gray_r;

    vga_timing_gen u_timing (
        .p_clock   (p_clock),
        .reset     (reset),
        .hc        (hc_s),
        .vc        (vc_s),
        .visible   (visible_s),
        .hsync_raw (hsync_raw_s),
        .vsync_raw (vsync_raw_s)
    );

    // Fetch schedule: words 1..79 four columns ahead of use, word 0 at the tail of the previous line.
    always_comb begin
        fetch_s       = 1'b0;
        target_line_s = vc_s;
        word_idx_s    = 7'd0;
        next_line_s   = (vc_s >= V_LAST) ? 10'd0 : (vc_s + 10'd1);
        if ((hc_s[2:0] == PH_FETCH) && (hc_s < H_FETCH_LIMIT)) begin
            target_line_s = vc_s;
            word_idx_s    = hc_s[9:3] + 7'd1;
            fetch_s       = (vc_s < V_VISIBLE);
        end else if (hc_s == H_ROW_FETCH) begin
            target_line_s = next_line_s;
            word_idx_s    = 7'd0;
            fetch_s       = (next_line_s < V_VISIBLE);
        end else begin
            target_line_s = vc_s;
            word_idx_s    = 7'd0;
            fetch_s       = 1'b0;
        end
        fetch_addr_s = row_base(target_line_s) + {8'd0, word_idx_s};
    end

    // Read port: address held between fetches, enable pulses for the cycle after each load.
    always_ff @(posedge p_clock or posedge reset) begin
        if (reset) begin
            addr_r <= 15'd0;
            ena_r  <= 1'b0;
        end else begin
            ena_r <= fetch_s;
            if (fetch_s) begin
                addr_r <= fetch_addr_s;
            end else begin
                addr_r <= addr_r;
            end
        end
    end

    // Two-stage word pipeline so cur_word covers columns 8k..8k+7 exactly.
    always_ff @(posedge p_clock or posedge reset) begin
        if (reset) begin
            next_word_r <= 16'd0;
            cur_word_r  <= 16'd0;
        end else begin
            if (hc_s[2:0] == PH_CAPTURE) begin
                next_word_r <= mem_data;
            end else begin
                next_word_r <= next_word_r;
            end
            if (hc_s[2:0] == PH_ADVANCE) begin
                cur_word_r <= next_word_r;
            end else begin
                cur_word_r <= cur_word_r;
            end
        end
    end

    // Gray for the current column: each source pixel spans two display columns.
    always_comb begin
        gray_s = 4'd0;
        if (visible_s) begin
`ifdef GRAY_BARS_EN
            if (test_mode) begin
                gray_s = hc_s[9:6];
            end else begin
                gray_s = nibble_sel(cur_word_r, hc_s[2:1]);
            end
`else
            gray_s = nibble_sel(cur_word_r, hc_s[2:1]);
`endif
        end else begin
            gray_s = 4'd0;
        end
    end

    // Output stage: sync and colour share one register delay so they stay aligned.
    always_ff @(posedge p_clock or posedge reset) begin
        if (reset) begin
            hsync_r <= 1'b1;
            vsync_r <= 1'b1;
            gray_r  <= 4'd0;
        end else begin
            hsync_r <= hsync_raw_s;
            vsync_r <= vsync_raw_s;
            gray_r  <= gray_s;
        end
    end

    assign addr  = addr_r;
    assign ena   = ena_r;
    assign hsync = hsync_r;
    assign vsync = vsync_r;
    assign red   = gray_r;
    assign green = gray_r;
    assign blue  = gray_r;

endmodule

// File: tb/tb_frame_buffer_vga_reader.sv
// Self-checking bench for frame_buffer_vga_reader: scenario table plus a per-cycle reference model.
module tb_frame_buffer_vga_reader;

    localparam int PAT_ADDR = 0;
    localparam int PAT_RAND = 1;
    localparam int PAT_ONES = 2;

    typedef struct {
        int pattern;
        int jump_line;
        int n_lines;
        bit test_mode;
    } scen_t;

    logic        p_clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] mem_data;
    logic [14:0] addr;
    logic        ena;
    logic        hsync;
    logic        vsync;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
`ifdef GRAY_BARS_EN
    logic        test_mode;
`endif

    always #20 p_clock = ~p_clock;

    frame_buffer_vga_reader dut (
        .p_clock   (p_clock),
        .reset     (reset),
`ifdef GRAY_BARS_EN
        .test_mode (test_mode),
`endif
        .mem_data  (mem_data),
        .addr      (addr),
        .ena       (ena),
        .hsync     (hsync),
        .vsync     (vsync),
        .red       (red),
        .green     (green),
        .blue      (blue)
    );

    // Frame buffer: synchronous read, data available two edges after the address load.
    logic [15:0] fb [0:19199];
    always @(posedge p_clock) begin
        if (ena) mem_data <= fb[addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    int h_m, v_m, t_rel, last_addr, ena_cnt, pattern_m;
    bit first_line, skip_line, hs_fell_seen, tmode;
    int w80_seq [8] = '{0, 0, 5, 5, 0, 0, 0, 0};

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s at h=%0d v=%0d: got %0d, expected %0d", name, h_m, v_m, act, exp);
        end
    endtask

    function automatic int exp_gray(input int h, input int v);
        int w;
        if (h >= 640 || v >= 480) return 0;
        if (tmode) return h / 64;
        if (first_line && h < 8) return 0;
        w = int'(fb[80 * (v / 2) + h / 8]);
        return (w >> (4 * ((h / 2) % 4))) & 15;
    endfunction

    function automatic int line_ena(input int v);
        return ((v < 480) ? 79 : 0) + ((((v + 1) % 525) < 480) ? 1 : 0);
    endfunction

    // One pixel cycle: predict from (h_m,v_m), sample on the falling edge, advance the model.
    task automatic step();
        int ena_exp, tl, g, hs_exp, vs_exp;
        @(posedge p_clock);
        ena_exp = 0;
        tl = (v_m + 1) % 525;
        if ((h_m % 8 == 4) && (h_m < 632) && (v_m < 480)) begin
            ena_exp = 1;
            last_addr = 80 * (v_m / 2) + (h_m + 4) / 8;
        end else if ((h_m == 796) && (tl < 480)) begin
            ena_exp = 1;
            last_addr = 80 * (tl / 2);
        end
        hs_exp = (h_m >= 656 && h_m <= 751) ? 0 : 1;
        vs_exp = (v_m == 490 || v_m == 491) ? 0 : 1;
        @(negedge p_clock);
        check("ena", int'(ena), ena_exp);
        check("addr", int'(addr), last_addr);
        check("hsync", int'(hsync), hs_exp);
        check("vsync", int'(vsync), vs_exp);
        if (!skip_line) begin
            g = exp_gray(h_m, v_m);
            check("red", int'(red), g);
            check("green", int'(green), g);
            check("blue", int'(blue), g);
            if (pattern_m == PAT_ADDR && v_m == 2 && h_m < 8 && !tmode)
                check("word80_seq", int'(red), w80_seq[h_m]);
        end
        ena_cnt += int'(ena);
        if (!hs_fell_seen && hsync == 1'b0) begin
            hs_fell_seen = 1'b1;
            check("first_hsync_fall_cycle", t_rel + 1, 657);
        end
        t_rel++;
        h_m++;
        if (h_m == 800) begin
            if (!skip_line) check("ena_per_line", ena_cnt, line_ena(v_m));
            h_m = 0;
            ena_cnt = 0;
            skip_line = 1'b0;
            first_line = 1'b0;
            v_m = (v_m + 1) % 525;
        end
    endtask

    // Move the DUT's line counter so late-frame lines are reached in a short run.
    task automatic jump_to(input int v);
        dut.u_timing.vc_r = 10'(v);
        v_m = v;
        skip_line = 1'b1;
    endtask

    task automatic do_reset(input int pattern, input bit tm);
        reset = 1'b1;
        #1;
        check("rst_hsync", int'(hsync), 1);
        check("rst_vsync", int'(vsync), 1);
        check("rst_red", int'(red), 0);
        check("rst_green", int'(green), 0);
        check("rst_blue", int'(blue), 0);
        check("rst_ena", int'(ena), 0);
        check("rst_addr", int'(addr), 0);
        for (int i = 0; i < 19200; i++) begin
            case (pattern)
                PAT_ADDR: fb[i] = 16'(i);
                PAT_ONES: fb[i] = 16'hFFFF;
                default:  fb[i] = 16'($urandom);
            endcase
        end
        pattern_m = pattern;
`ifdef GRAY_BARS_EN
        test_mode = tm;
        tmode = tm;
`else
        tmode = 1'b0;
        if (tm) $display("note: test_mode scenario runs as memory gray (GRAY_BARS_EN undefined)");
`endif
        repeat (3) @(negedge p_clock);
        reset = 1'b0;
        h_m = 0;
        v_m = 0;
        t_rel = 0;
        last_addr = 0;
        ena_cnt = 0;
        first_line = 1'b1;
        skip_line = 1'b0;
        hs_fell_seen = 1'b0;
    endtask

    task automatic run_scen(input scen_t sc);
        do_reset(sc.pattern, sc.test_mode);
        repeat (100) step();
        if (sc.jump_line > 0) jump_to(sc.jump_line);
        repeat (sc.n_lines * 800 - 100) step();
    endtask

    initial begin
        scen_t tbl [7];
        tbl[0] = '{PAT_ADDR, 0,   4, 1'b0};
        tbl[1] = '{PAT_RAND, 10,  3, 1'b0};
        tbl[2] = '{PAT_ADDR, 477, 5, 1'b0};
        tbl[3] = '{PAT_RAND, 488, 5, 1'b0};
        tbl[4] = '{PAT_ADDR, 522, 5, 1'b0};
        tbl[5] = '{PAT_ONES, 200, 3, 1'b0};
        tbl[6] = '{PAT_RAND, 30,  2, 1'b1};
`ifdef GRAY_BARS_EN
        test_mode = 1'b0;
`endif
        @(negedge p_clock);
        for (int s = 0; s < 7; s++) begin
            run_scen(tbl[s]);
        end

        // Reset asserted mid-frame at (300,100), held three cycles, then scanning restarts at (0,0).
        do_reset(PAT_RAND, 1'b0);
        repeat (100) step();
        jump_to(100);
        repeat (200) step();
        do_reset(PAT_RAND, 1'b0);
        repeat (1600) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
